ray_scan_gen: RTL and testbench
===============================

// Module: ray_scan_gen
// PURPOSE
//  Camera ray generator: scans a full pixel frame and emits one unnormalised Q-format eye->pixel direction per pixel.
//  Runtime-loaded camera basis; runtime pixel stride (subsampled preview frames); valid/ready backpressure; abortable.
//  Incremental: dir(x,y) = BASE + x*U + y*V built by adders only, no multipliers or FP IP.
//  Sits between frame control and the ray normaliser / intersection pipeline.
// PARAMETERS
//  H_RES  1024  pixels per row
//  V_RES  768   rows per frame
//  XW     11    pix_x_out width, >= clog2(H_RES)
//  YW     10    pix_y_out width, >= clog2(V_RES)
//  W      32    signed fixed-point component width
//  FRAC   16    fractional bits (Q(W-FRAC).FRAC)
// PORTS
//  clk_in            in   1    clock; single clock domain
//  rst_n_in          in   1    asynchronous, active-low reset
//  start_in          in   1    begin frame; accepted only in IDLE
//  abort_in          in   1    cancel frame
//  stride_log2_in    in   2    pixel stride = 1<<stride_log2_in (1,2,4,8)
//  base_{x,y,z}_in   in   W    direction at pixel (0,0) = corner - eye
//  u_{x,y,z}_in      in   W    per-pixel horizontal step
//  v_{x,y,z}_in      in   W    per-row vertical step
//  busy_out          out  1    frame in progress (LOAD or RUN)
//  done_out          out  1    one-cycle pulse at frame completion
//  ray_valid_out     out  1    ray beat valid
//  ray_ready_in      in   1    downstream accepts beat
//  ray_{x,y,z}_out   out  W    direction components
//  pix_x_out         out  XW   pixel column of the beat
//  pix_y_out         out  YW   pixel row of the beat
//  eol_out           out  1    beat is last of its row
//  last_out          out  1    beat is last of the frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, all internal regs 0; asynchronous assert, synchronous deassert.
//  FSM IDLE -> LOAD (start_in & !abort_in) -> RUN -> DONE -> IDLE.
//   IDLE: base/u/v/stride sampled into config regs on the accepting edge; later input changes ignored.
//   LOAD (1 cycle): ustep = u<<s, vstep = v<<s (arithmetic, wraps); row_dir = cur_dir = base; x=y=0.
//   RUN: ray_valid_out=1 from first RUN cycle (2 cycles after start edge). Beat advances only on valid&ready.
//    Without handshake, all ray/pix/eol/last outputs hold stable.
//    Advance: x+=stride, cur_dir+=ustep; if x+stride >= H_RES: x=0, y+=stride, row_dir+=vstep, cur_dir=row_dir+vstep.
//    eol_out = (x+stride >= H_RES); last_out = eol_out & (y+stride >= V_RES).
//    Handshake on last beat -> DONE; valid drops that next cycle.
//   DONE: done_out=1 one cycle, busy_out=0, -> IDLE. Back-to-back start accepted in the cycle after DONE.
//  Beats per frame = ceil(H_RES/stride)*ceil(V_RES/stride); zero bubbles when ready held high.
//  Arithmetic: two's-complement modulo 2^W, no saturation, no rounding; pix coords exact integers.
//  abort_in: highest priority in every state; next cycle IDLE, valid=0, busy=0, done never pulses.
//   Abort with start in IDLE: stays IDLE. Abort on same edge as last handshake: beat counts as consumed, no done.
//  start_in while busy: ignored, no effect on frame in flight.
//  Stride > H_RES or V_RES: single column/row; eol/last computed by the same compares.
// STRUCTURE
//  Package ray_scan_pkg: state_t enum {IDLE,LOAD,RUN,DONE}; typedef vec3_fx_t (3 x logic signed [W-1:0]);
//   FRAC/W defaults; vec3 add and arithmetic-shift functions.
//  Sub-module vec3_acc: 3-lane W-bit load/add register (load, add_en, step), instanced for row_dir and cur_dir.
//  Top holds FSM, x/y counters, config regs, output regs.
// TESTING  (H_RES=4,V_RES=3,W=32,FRAC=16; base=(FFFF0000,0,00010000) u=(00008000,0,0) v=(0,00004000,0))
//  Stride 1, ready=1:
//   12 beats, first pix(0,0) dir(FFFF0000,0,10000).
//   Beat 5: pix(0,1) dir(FFFF0000,4000,10000).
//   Beat 12: pix(3,2) dir(00008000,00008000,10000), eol=last=1.
//   done 1 cycle after; eol on beats 4,8,12.
//  stride_log2=1 -> 4 beats (0,0),(2,0),(0,2),(2,2); last dir (0,00008000,10000).
//  ready low 3 cycles at beat 3 -> outputs frozen at pix(2,0); beat 4 follows, none skipped/duplicated.
//  abort after 5 handshakes -> next cycle valid=0,busy=0, no done; new start restarts at pix(0,0) with new base.
//  base_x=7FFF0000,u_x=00010000 -> pix(1,0) x=80000000 (wrap, no saturation).
//  rst_n_in low mid-RUN between edges -> outputs 0 immediately; release + start gives a clean frame.

Source files
------------

// File: rtl/ray_scan_gen_pkg.sv
// Shared types and fixed-point vector helpers for the camera ray scan generator.
package ray_scan_gen_pkg;

    localparam int VEC_W    = 32;
    localparam int VEC_FRAC = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [VEC_W-1:0] x;
        logic signed [VEC_W-1:0] y;
        logic signed [VEC_W-1:0] z;
    } vec3_fx_t;

    // Lane-wise two's-complement add; wraps modulo 2^VEC_W.
    function automatic vec3_fx_t vec3_add(input vec3_fx_t a, input vec3_fx_t b);
        vec3_fx_t r;
        r.x = a.x + b.x;
        r.y = a.y + b.y;
        r.z = a.z + b.z;
        return r;
    endfunction

    function automatic vec3_fx_t vec3_shl(input vec3_fx_t a, input logic [1:0] sh);
        vec3_fx_t r;
        r.x = a.x <<< sh;
        r.y = a.y <<< sh;
        r.z = a.z <<< sh;
        return r;
    endfunction

endpackage

// File: rtl/ray_scan_gen_if.sv
// Ray beat stream: one eye->pixel direction per beat with pixel coordinates and row/frame markers.
interface ray_scan_gen_if
    import ray_scan_gen_pkg::*;
#(
    parameter int W  = VEC_W,
    parameter int XW = 11,
    parameter int YW = 10
) ();

    logic                ray_valid_out;
    logic                ray_ready_in;
    logic signed [W-1:0] ray_x_out;
    logic signed [W-1:0] ray_y_out;
    logic signed [W-1:0] ray_z_out;
    logic [XW-1:0]       pix_x_out;
    logic [YW-1:0]       pix_y_out;
    logic                eol_out;
    logic                last_out;

    modport master (
        output ray_valid_out, ray_x_out, ray_y_out, ray_z_out,
               pix_x_out, pix_y_out, eol_out, last_out,
        input  ray_ready_in
    );

    modport slave (
        input  ray_valid_out, ray_x_out, ray_y_out, ray_z_out,
               pix_x_out, pix_y_out, eol_out, last_out,
        output ray_ready_in
    );

endinterface

// File: rtl/ray_scan_gen_vec3_acc.sv
// Three-lane load/add register used for the row-start and current-pixel direction accumulators.
module ray_scan_gen_vec3_acc
    import ray_scan_gen_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     load_i,
    input  vec3_fx_t load_val_i,
    input  logic     add_en_i,
    input  vec3_fx_t step_i,
    output vec3_fx_t acc_o
);

    vec3_fx_t acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (add_en_i) begin
            acc_d = vec3_add(acc_q, step_i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ray_scan_gen.sv
// Frame scanner: walks the pixel grid at a runtime stride and emits dir = BASE + x*U + y*V
// built purely from incremental adds, with valid/ready backpressure and abort.
module ray_scan_gen
    import ray_scan_gen_pkg::*;
#(
    parameter int H_RES = 1024,
    parameter int V_RES = 768,
    parameter int XW    = 11,
    parameter int YW    = 10,
    parameter int W     = VEC_W,
    parameter int FRAC  = VEC_FRAC
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic [1:0]          stride_log2_in,
    input  logic signed [W-1:0] base_x_in,
    input  logic signed [W-1:0] base_y_in,
    input  logic signed [W-1:0] base_z_in,
    input  logic signed [W-1:0] u_x_in,
    input  logic signed [W-1:0] u_y_in,
    input  logic signed [W-1:0] u_z_in,
    input  logic signed [W-1:0] v_x_in,
    input  logic signed [W-1:0] v_y_in,
    input  logic signed [W-1:0] v_z_in,
    output logic                busy_out,
    output logic                done_out,
    ray_scan_gen_if.master      ray_if
);

    // The datapath uses the package vector type, so the component width is fixed there.
    if (W != VEC_W || FRAC >= W) begin : g_bad_params
        $error("ray_scan_gen: W must equal VEC_W and FRAC must be below W");
    end

    localparam logic [XW:0] H_LIM = (XW+1)'(H_RES);
    localparam logic [YW:0] V_LIM = (YW+1)'(V_RES);

    state_t      state_q, state_d;
    logic [1:0]  stride_q;
    vec3_fx_t    base_q, u_q, v_q, ustep_q, vstep_q;
    vec3_fx_t    base_in_v, u_in_v, v_in_v;
    vec3_fx_t    row_dir, cur_dir, cur_load_val;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;
    logic        in_load, in_run, fire, accept, eol, last;

    assign base_in_v = '{x: base_x_in, y: base_y_in, z: base_z_in};
    assign u_in_v    = '{x: u_x_in,    y: u_y_in,    z: u_z_in};
    assign v_in_v    = '{x: v_x_in,    y: v_y_in,    z: v_z_in};

    assign in_load = (state_q == LOAD);
    assign in_run  = (state_q == RUN);
    assign fire    = in_run && ray_if.ray_ready_in;
    assign accept  = (state_q == IDLE) && start_in && !abort_in;

    // One guard bit so x+stride / y+stride cannot wrap before the compare.
    assign x_sum = {1'b0, x_q} + ((XW+1)'(1) << stride_q);
    assign y_sum = {1'b0, y_q} + ((YW+1)'(1) << stride_q);
    assign eol   = (x_sum >= H_LIM);
    assign last  = eol && (y_sum >= V_LIM);

    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_in) state_d = LOAD;
                LOAD:    state_d = RUN;
                RUN:     if (fire && last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (in_load) begin
            x_d = '0;
            y_d = '0;
        end else if (fire) begin
            if (eol) begin
                x_d = '0;
                y_d = y_sum[YW-1:0];
            end else begin
                x_d = x_sum[XW-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            stride_q <= '0;
            base_q   <= '0;
            u_q      <= '0;
            v_q      <= '0;
            ustep_q  <= '0;
            vstep_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (accept) begin
                stride_q <= stride_log2_in;
                base_q   <= base_in_v;
                u_q      <= u_in_v;
                v_q      <= v_in_v;
            end
            if (in_load) begin
                ustep_q <= vec3_shl(u_q, stride_q);
                vstep_q <= vec3_shl(v_q, stride_q);
            end
        end
    end

    // On a row wrap the current pixel restarts at the new row start, i.e. old row_dir + vstep.
    assign cur_load_val = in_load ? base_q : vec3_add(row_dir, vstep_q);

    ray_scan_gen_vec3_acc u_row_acc (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_i     (in_load),
        .load_val_i (base_q),
        .add_en_i   (fire && eol),
        .step_i     (vstep_q),
        .acc_o      (row_dir)
    );

    ray_scan_gen_vec3_acc u_cur_acc (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_i     (in_load || (fire && eol)),
        .load_val_i (cur_load_val),
        .add_en_i   (fire && !eol),
        .step_i     (ustep_q),
        .acc_o      (cur_dir)
    );

    assign busy_out             = in_load || in_run;
    assign done_out             = (state_q == DONE);
    assign ray_if.ray_valid_out = in_run;
    assign ray_if.ray_x_out     = cur_dir.x;
    assign ray_if.ray_y_out     = cur_dir.y;
    assign ray_if.ray_z_out     = cur_dir.z;
    assign ray_if.pix_x_out     = x_q;
    assign ray_if.pix_y_out     = y_q;
    assign ray_if.eol_out       = in_run && eol;
    assign ray_if.last_out      = in_run && last;

endmodule

// File: tb/tb_ray_scan_gen.sv
// Directed and randomized frames for ray_scan_gen against a closed-form direction model.
module tb_ray_scan_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int W  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  sl = 2'd0;
    logic [31:0] bx = '0, by = '0, bz = '0;
    logic [31:0] ux = '0, uy = '0, uz = '0;
    logic [31:0] vx = '0, vy = '0, vz = '0;
    logic        busy, done;

    ray_scan_gen_if #(.W(W), .XW(XW), .YW(YW)) rif ();

    ray_scan_gen #(
        .H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .W(W), .FRAC(16)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort),
        .stride_log2_in(sl),
        .base_x_in(bx), .base_y_in(by), .base_z_in(bz),
        .u_x_in(ux), .u_y_in(uy), .u_z_in(uz),
        .v_x_in(vx), .v_y_in(vy), .v_z_in(vz),
        .busy_out(busy), .done_out(done),
        .ray_if(rif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        logic          eol;
        logic          last;
        logic [31:0]   dx;
        logic [31:0]   dy;
        logic [31:0]   dz;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       cap[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] c_b[3], c_u[3], c_v[3];
    int          c_s;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic beat_t obs_beat();
        beat_t b;
        b.px = rif.pix_x_out;
        b.py = rif.pix_y_out;
        b.eol = rif.eol_out;
        b.last = rif.last_out;
        b.dx = rif.ray_x_out;
        b.dy = rif.ray_y_out;
        b.dz = rif.ray_z_out;
        return b;
    endfunction

    // Reference: every visited pixel gets base + x*u + y*v directly, modulo 2^32.
    task automatic build_model();
        int s;
        s = 1 << c_s;
        exp_q.delete();
        for (int y = 0; y < V; y += s) begin
            for (int x = 0; x < H; x += s) begin
                beat_t b;
                b.px = XW'(x);
                b.py = YW'(y);
                b.eol = (x + s >= H);
                b.last = b.eol && (y + s >= V);
                b.dx = c_b[0] + 32'(x) * c_u[0] + 32'(y) * c_v[0];
                b.dy = c_b[1] + 32'(x) * c_u[1] + 32'(y) * c_v[1];
                b.dz = c_b[2] + 32'(x) * c_u[2] + 32'(y) * c_v[2];
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic set_cfg(input logic [31:0] b0, b1, b2, u0, u1, u2, v0, v1, v2, input int s);
        c_b[0] = b0; c_b[1] = b1; c_b[2] = b2;
        c_u[0] = u0; c_u[1] = u1; c_u[2] = u2;
        c_v[0] = v0; c_v[1] = v1; c_v[2] = v2;
        c_s = s;
    endtask

    task automatic drive_cfg();
        bx = c_b[0]; by = c_b[1]; bz = c_b[2];
        ux = c_u[0]; uy = c_u[1]; uz = c_u[2];
        vx = c_v[0]; vy = c_v[1]; vz = c_v[2];
        sl = 2'(c_s);
    endtask

    task automatic scramble();
        bx = $urandom; by = $urandom; bz = $urandom;
        ux = $urandom; uy = $urandom; uz = $urandom;
        vx = $urandom; vy = $urandom; vz = $urandom;
        sl = 2'($urandom_range(0, 3));
        start = 1'($urandom_range(0, 1));
    endtask

    // mode 0: ready high; 1: random ready and input noise; 2: ready low 3 cycles at beat 3.
    task automatic run_frame(input int mode, input int abort_at);
        int   idx = 0;
        int   hs = 0;
        int   stall = 0;
        bit   fin = 0;
        logic rdy;
        logic saw;
        build_model();
        cap.delete();
        drive_cfg();
        rif.ray_ready_in = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("load_phase", 128'({busy, rif.ray_valid_out, done}), 128'(3'b100));
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (idx < exp_q.size()) begin
                if (abort_at > 0 && hs == abort_at) begin
                    start = 1'b0;
                    abort = 1'b1;
                    rif.ray_ready_in = 1'b0;
                    @(posedge clk);
                    #1 abort = 1'b0;
                    @(negedge clk);
                    chk("abort_next", 128'({busy, rif.ray_valid_out, done}), 128'(3'b000));
                    saw = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        saw = saw | done | busy | rif.ray_valid_out;
                    end
                    chk("abort_quiet", 128'(saw), 128'(1'b0));
                    rif.ray_ready_in = 1'b1;
                    fin = 1;
                end else begin
                    chk($sformatf("beat%0d", idx), 128'({rif.ray_valid_out, obs_beat()}),
                        128'({1'b1, exp_q[idx]}));
                    rdy = 1'b1;
                    if (mode == 1) begin
                        rdy = ($urandom_range(0, 3) != 0);
                        scramble();
                    end else if (mode == 2 && idx == 2 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end
                    rif.ray_ready_in = rdy;
                    if (rdy) begin
                        cap.push_back(obs_beat());
                        idx++;
                        hs++;
                    end
                end
            end else begin
                start = 1'b0;
                chk("done_pulse", 128'({rif.ray_valid_out, busy, done}), 128'(3'b001));
                @(negedge clk);
                chk("after_done", 128'({rif.ray_valid_out, busy, done}), 128'(3'b000));
                fin = 1;
            end
        end
        if (!fin) chk("frame_timeout", 128'(0), 128'(1));
        start = 1'b0;
        rif.ray_ready_in = 1'b1;
    endtask

    function automatic logic [11:0] eol_mask();
        logic [11:0] m;
        m = '0;
        for (int i = 0; i < 12 && i < cap.size(); i++) m[i] = cap[i].eol;
        return m;
    endfunction

    function automatic logic [11:0] last_mask();
        logic [11:0] m;
        m = '0;
        for (int i = 0; i < 12 && i < cap.size(); i++) m[i] = cap[i].last;
        return m;
    endfunction

    initial begin
        rif.ray_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_held", 128'({rif.ray_valid_out, busy, done, rif.eol_out, rif.last_out,
            rif.pix_x_out, rif.pix_y_out, rif.ray_x_out, rif.ray_y_out, rif.ray_z_out}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_idle", 128'({rif.ray_valid_out, busy, done}), 128'(3'b000));

        // Stride 1, ready held high.
        set_cfg(32'hFFFF0000, 32'h0, 32'h00010000, 32'h00008000, 32'h0, 32'h0,
                32'h0, 32'h00004000, 32'h0, 0);
        run_frame(0, 0);
        chk("s1_count", 128'(cap.size()), 128'(12));
        while (cap.size() < 12) cap.push_back('0);
        chk("s1_beat1", 128'({cap[0].px, cap[0].py, cap[0].dx, cap[0].dy, cap[0].dz}),
            128'({11'd0, 10'd0, 32'hFFFF0000, 32'h0, 32'h00010000}));
        chk("s1_beat5", 128'({cap[4].px, cap[4].py, cap[4].dx, cap[4].dy, cap[4].dz}),
            128'({11'd0, 10'd1, 32'hFFFF0000, 32'h00004000, 32'h00010000}));
        chk("s1_beat12", 128'({cap[11].px, cap[11].py, cap[11].dx, cap[11].dy, cap[11].dz}),
            128'({11'd3, 10'd2, 32'h00008000, 32'h00008000, 32'h00010000}));
        chk("s1_eol_beats", 128'(eol_mask()), 128'(12'h888));
        chk("s1_last_beat", 128'(last_mask()), 128'(12'h800));

        // Stride 2 starts right after the previous frame returned to IDLE.
        set_cfg(32'hFFFF0000, 32'h0, 32'h00010000, 32'h00008000, 32'h0, 32'h0,
                32'h0, 32'h00004000, 32'h0, 1);
        run_frame(0, 0);
        chk("s2_count", 128'(cap.size()), 128'(4));
        while (cap.size() < 4) cap.push_back('0);
        chk("s2_pixels", 128'({cap[0].px, cap[0].py, cap[1].px, cap[1].py,
                                cap[2].px, cap[2].py, cap[3].px, cap[3].py}),
            128'({11'd0, 10'd0, 11'd2, 10'd0, 11'd0, 10'd2, 11'd2, 10'd2}));
        chk("s2_last_dir", 128'({cap[3].dx, cap[3].dy, cap[3].dz}),
            128'({32'h0, 32'h00008000, 32'h00010000}));

        // Backpressure: ready low for 3 cycles while beat 3 is presented.
        set_cfg(32'hFFFF0000, 32'h0, 32'h00010000, 32'h00008000, 32'h0, 32'h0,
                32'h0, 32'h00004000, 32'h0, 0);
        run_frame(2, 0);
        chk("stall_count", 128'(cap.size()), 128'(12));

        // Abort after 5 handshakes, then restart with a new base.
        run_frame(0, 5);
        set_cfg(32'h00020000, 32'h11110000, 32'hFFFF8000, 32'h00008000, 32'h0, 32'h0,
                32'h0, 32'h00004000, 32'h0, 0);
        run_frame(0, 0);
        chk("restart_first", 128'({cap[0].px, cap[0].py, cap[0].dx, cap[0].dy, cap[0].dz}),
            128'({11'd0, 10'd0, 32'h00020000, 32'h11110000, 32'hFFFF8000}));

        // Abort together with start in IDLE keeps the block idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start", 128'({busy, rif.ray_valid_out, done}), 128'(3'b000));
        @(negedge clk);
        chk("abort_start2", 128'({busy, rif.ray_valid_out, done}), 128'(3'b000));

        // Wrap-around without saturation.
        set_cfg(32'h7FFF0000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 0);
        run_frame(0, 0);
        chk("wrap_x", 128'({cap[1].px, cap[1].dx}), 128'({11'd1, 32'h80000000}));

        // Asynchronous reset between clock edges during RUN.
        set_cfg(32'hFFFF0000, 32'h0, 32'h00010000, 32'h00008000, 32'h0, 32'h0,
                32'h0, 32'h00004000, 32'h0, 0);
        drive_cfg();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", 128'({busy, rif.ray_valid_out}), 128'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 128'({rif.ray_valid_out, busy, done, rif.eol_out, rif.last_out,
            rif.pix_x_out, rif.pix_y_out, rif.ray_x_out, rif.ray_y_out, rif.ray_z_out}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 0);
        chk("post_reset_count", 128'(cap.size()), 128'(12));

        // Randomized configurations, ready and input noise.
        for (int r = 0; r < 6; r++) begin
            set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom_range(0, 3));
            run_frame(1, (r == 3) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
